// File: rtl/psum_accum_buffer_if.sv
// Psum lane input bus and quantized drain stream of psum_accum_buffer.
// master drives lanes and accepts beats; slave is the accumulator buffer.
interface psum_accum_buffer_if #(
   parameter int NUM_COLS  = 32,
   parameter int PSUM_BW   = 32,
   parameter int ADDR_PSUM = 11,
   parameter int OUT_BW    = 8
);
   logic [NUM_COLS-1:0]           psum_valid;
   logic [PSUM_BW*NUM_COLS-1:0]   psum_rows;
   logic [ADDR_PSUM*NUM_COLS-1:0] psum_addrs;
   logic                          out_valid;
   logic                          out_ready;
   logic [OUT_BW*NUM_COLS-1:0]    out_data;
   logic [ADDR_PSUM-1:0]          out_addr;

   modport master (
      output psum_valid,
      output psum_rows,
      output psum_addrs,
      output out_ready,
      input  out_valid,
      input  out_data,
      input  out_addr
   );

   modport slave (
      input  psum_valid,
      input  psum_rows,
      input  psum_addrs,
      input  out_ready,
      output out_valid,
      output out_data,
      output out_addr
   );
endinterface

// File: rtl/psum_accum_buffer.sv
// Per-column psum accumulation banks with INT8 requantized drain stream.
// Optional QUANT_ROUND_EN: round-half-up (saturating add) before the shift.
module psum_accum_buffer #(
   parameter int NUM_COLS   = 32,
   parameter int PSUM_BW    = 32,
   parameter int ADDR_PSUM  = 11,
   parameter int BANK_DEPTH = 64,
   parameter int OUT_BW     = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic                 acc_done_i,
   input  logic [4:0]           shift_i,
   input  logic [ADDR_PSUM:0]   drain_len_i,
   psum_accum_buffer_if.slave   bus,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 addr_err_o
);

   localparam int LW = $clog2(BANK_DEPTH);
   localparam int CW = ADDR_PSUM + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(BANK_DEPTH);
   localparam logic signed [PSUM_BW-1:0] QMAX =
      PSUM_BW'((2 ** (OUT_BW - 1)) - 1);
   localparam logic signed [PSUM_BW-1:0] QMIN = ~QMAX;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [LW-1:0]  clr_q;
   logic           fl_q;
   logic [4:0]     shift_q;
   logic [CW-1:0]  len_q;
   logic [CW-1:0]  rd_ptr_q;
   logic           addr_err_q;

   logic [PSUM_BW-1:0] mem_q [NUM_COLS][BANK_DEPTH];

   logic [NUM_COLS-1:0] s0_vld_q;
   logic [NUM_COLS-1:0] s1_vld_q;
   logic [LW-1:0]       s0_addr_q [NUM_COLS];
   logic [PSUM_BW-1:0]  s0_data_q [NUM_COLS];
   logic [LW-1:0]       s1_addr_q [NUM_COLS];
   logic [PSUM_BW-1:0]  s1_sum_q  [NUM_COLS];

   logic [ADDR_PSUM-1:0] lane_addr [NUM_COLS];
   logic [NUM_COLS-1:0]  lane_ok;
   logic [PSUM_BW-1:0]   sum_d [NUM_COLS];

   logic                       f_vld_q;
   logic [ADDR_PSUM-1:0]       f_addr_q;
   logic [OUT_BW*NUM_COLS-1:0] f_data_q;
   logic                       o_vld_q;
   logic [ADDR_PSUM-1:0]       o_addr_q;
   logic [OUT_BW*NUM_COLS-1:0] o_data_q;
   logic [OUT_BW*NUM_COLS-1:0] q_d;

   logic          start_go;
   logic          in_accum;
   logic [CW-1:0] drain_n;
   logic          out_load;
   logic          f_free;
   logic          issue;
   logic          drain_end;

   // Requantize one accumulator: optional rounding, arithmetic shift, clamp
   function automatic logic [OUT_BW-1:0] quant(
      input logic [PSUM_BW-1:0] acc,
      input logic [4:0]         sh
   );
      logic signed [PSUM_BW-1:0] v;
      logic signed [PSUM_BW-1:0] q;
`ifdef QUANT_ROUND_EN
      logic [PSUM_BW-1:0] r;
`endif
      v = acc;
`ifdef QUANT_ROUND_EN
      if (sh != 5'd0) begin
         r = acc + (PSUM_BW'(1) << (sh - 5'd1));
         // bias is positive, so overflow only turns a positive into negative
         if (!acc[PSUM_BW-1] && r[PSUM_BW-1])
            v = {1'b0, {(PSUM_BW-1){1'b1}}};
         else
            v = r;
      end
`endif
      q = v >>> sh;
      if (q > QMAX)
         q = QMAX;
      else if (q < QMIN)
         q = QMIN;
      return q[OUT_BW-1:0];
   endfunction

   // Control strobes and drain handshake bookkeeping
   always_comb begin
      start_go  = (state_q == S_IDLE) && start_i;
      in_accum  = (state_q == S_ACCUM);
      drain_n   = (len_q > DEPTH_C) ? DEPTH_C : len_q;
      out_load  = f_vld_q && (!o_vld_q || bus.out_ready);
      f_free    = !f_vld_q || out_load;
      issue     = (state_q == S_DRAIN) && (rd_ptr_q < drain_n) && f_free;
      drain_end = (rd_ptr_q >= drain_n) && !f_vld_q
                  && (!o_vld_q || bus.out_ready);
   end

   // Lane unpack, range check and RMW add with S1 forwarding
   always_comb begin
      lane_ok = '0;
      for (int i = 0; i < NUM_COLS; i++) begin
         lane_addr[i] = bus.psum_addrs[ADDR_PSUM*i +: ADDR_PSUM];
         lane_ok[i]   = (32'(lane_addr[i]) < BANK_DEPTH);
         if (s1_vld_q[i] && (s1_addr_q[i] == s0_addr_q[i]))
            sum_d[i] = s1_sum_q[i] + s0_data_q[i];
         else
            sum_d[i] = mem_q[i][s0_addr_q[i]] + s0_data_q[i];
      end
   end

   // Quantized read of the entry addressed by the drain pointer
   always_comb begin
      q_d = '0;
      for (int i = 0; i < NUM_COLS; i++)
         q_d[OUT_BW*i +: OUT_BW] = quant(mem_q[i][rd_ptr_q[LW-1:0]], shift_q);
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (reset_i)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // FSM next state and status outputs
   always_comb begin
      state_d = state_q;
      busy_o  = (state_q != S_IDLE);
      done_o  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i)
               state_d = S_CLEAR;
         end
         S_CLEAR: begin
            if (clr_q == LW'(BANK_DEPTH - 1))
               state_d = S_ACCUM;
         end
         S_ACCUM: begin
            if (acc_done_i)
               state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (fl_q)
               state_d = (drain_n == '0) ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_end)
               state_d = S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Tile configuration, clear/flush counters and drain pointer
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         clr_q    <= '0;
         fl_q     <= 1'b0;
         shift_q  <= '0;
         len_q    <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (start_go) begin
            shift_q <= shift_i;
            len_q   <= drain_len_i;
            clr_q   <= '0;
         end else if (state_q == S_CLEAR) begin
            clr_q <= clr_q + LW'(1);
         end
         fl_q <= (state_q == S_FLUSH) ? ~fl_q : 1'b0;
         if (state_q == S_FLUSH)
            rd_ptr_q <= '0;
         else if (issue)
            rd_ptr_q <= rd_ptr_q + CW'(1);
      end
   end

   // Sticky out-of-range flag, cleared when a new tile starts
   always_ff @(posedge clk_i) begin
      if (reset_i)
         addr_err_q <= 1'b0;
      else if (start_go)
         addr_err_q <= 1'b0;
      else if (in_accum && |(bus.psum_valid & ~lane_ok))
         addr_err_q <= 1'b1;
   end

   // RMW pipeline valids: only in-range beats seen in ACCUM enter S0
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s0_vld_q <= '0;
         s1_vld_q <= '0;
      end else begin
         s0_vld_q <= in_accum ? (bus.psum_valid & lane_ok) : '0;
         s1_vld_q <= s0_vld_q;
      end
   end

   // RMW pipeline payload
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_COLS; i++) begin
         s0_addr_q[i] <= lane_addr[i][LW-1:0];
         s0_data_q[i] <= bus.psum_rows[PSUM_BW*i +: PSUM_BW];
         s1_addr_q[i] <= s0_addr_q[i];
         s1_sum_q[i]  <= sum_d[i];
      end
   end

   // Bank write port: zero-fill during CLEAR, S1 write-back otherwise
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_COLS; i++) begin
         if (state_q == S_CLEAR)
            mem_q[i][clr_q] <= '0;
         else if (s1_vld_q[i])
            mem_q[i][s1_addr_q[i]] <= s1_sum_q[i];
      end
   end

   // Prefetch stage: registered bank read, refilled whenever it moves on
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         f_vld_q  <= 1'b0;
         f_addr_q <= '0;
         f_data_q <= '0;
      end else if (issue) begin
         f_vld_q  <= 1'b1;
         f_addr_q <= rd_ptr_q[ADDR_PSUM-1:0];
         f_data_q <= q_d;
      end else if (out_load) begin
         f_vld_q <= 1'b0;
      end
   end

   // Output register: holds while a beat is offered and not accepted
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         o_vld_q  <= 1'b0;
         o_addr_q <= '0;
         o_data_q <= '0;
      end else if (out_load) begin
         o_vld_q  <= 1'b1;
         o_addr_q <= f_addr_q;
         o_data_q <= f_data_q;
      end else if (bus.out_ready) begin
         o_vld_q <= 1'b0;
      end
   end

   assign bus.out_valid = o_vld_q;
   assign bus.out_addr  = o_addr_q;
   assign bus.out_data  = o_data_q;
   assign addr_err_o    = addr_err_q;

endmodule
